// File: rtl/fetch_stage_if.sv
// Instruction-cache request/ready bus between the fetch stage (master) and the cache (slave).
`default_nettype none

interface fetch_stage_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ready_i;
   logic [31:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_ready_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_ready_i,
      output imem_rdata_i
   );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, issues I-cache requests, holds returned words under stall
// and parks redirects that arrive while a cache access is still outstanding.
`default_nettype none

module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 stall_f_i,
   input  logic                 redirect_i,
   input  logic [31:0]          redirect_pc_i,
   fetch_stage_if.master        imem,
   output logic [31:0]          pc_plus_4_f_o,
   output logic [31:0]          instr_f_o,
   output logic                 instr_valid_f_o,
   output logic                 imem_stall_o
);

   typedef enum logic [1:0] {
      ST_FETCH   = 2'd0,
      ST_HOLD    = 2'd1,
      ST_DISCARD = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [31:0] w_pc_nxt;
   logic [31:0] r_hold_instr;
   logic [31:0] w_hold_nxt;
   logic [31:0] r_target;
   logic [31:0] w_target_nxt;

   logic [31:0] w_pc_plus4;
   logic [31:0] w_redir_pc;
   logic        w_req;
   logic [31:0] w_instr;
   logic        w_valid;
   logic        w_stall;

   assign w_pc_plus4 = r_pc + 32'd4;
   assign w_redir_pc = {redirect_pc_i[31:2], 2'b00};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state      <= ST_FETCH;
         r_pc         <= RESET_PC;
         r_hold_instr <= 32'h0;
         r_target     <= 32'h0;
      end else begin
         r_state      <= w_state_nxt;
         r_pc         <= w_pc_nxt;
         r_hold_instr <= w_hold_nxt;
         r_target     <= w_target_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_hold_nxt   = r_hold_instr;
      w_target_nxt = r_target;
      w_req        = 1'b0;
      w_instr      = 32'h0;
      w_valid      = 1'b0;
      w_stall      = 1'b0;
      case (r_state)
         ST_FETCH: begin
            w_req   = 1'b1;
            w_stall = ~imem.imem_ready_i;
            if (imem.imem_ready_i) begin
               w_instr = imem.imem_rdata_i;
               w_valid = 1'b1;
               if (redirect_i) begin
                  w_pc_nxt = w_redir_pc;
               end else if (stall_f_i) begin
                  w_hold_nxt  = imem.imem_rdata_i;
                  w_state_nxt = ST_HOLD;
               end else begin
                  w_pc_nxt = w_pc_plus4;
               end
            end else if (redirect_i) begin
               // Address must stay put until the pending access completes.
               w_target_nxt = w_redir_pc;
               w_state_nxt  = ST_DISCARD;
            end
         end
         ST_HOLD: begin
            w_instr = r_hold_instr;
            w_valid = 1'b1;
            if (redirect_i) begin
               w_pc_nxt    = w_redir_pc;
               w_state_nxt = ST_FETCH;
            end else if (!stall_f_i) begin
               w_pc_nxt    = w_pc_plus4;
               w_state_nxt = ST_FETCH;
            end
         end
         ST_DISCARD: begin
            w_req   = 1'b1;
            w_stall = 1'b1;
            if (imem.imem_ready_i) begin
               w_pc_nxt    = redirect_i ? w_redir_pc : r_target;
               w_state_nxt = ST_FETCH;
            end else if (redirect_i) begin
               w_target_nxt = w_redir_pc;
            end
         end
         default: begin
            w_state_nxt = ST_FETCH;
         end
      endcase
   end

   // Reset forces the handshake quiet immediately, abandoning any in-flight request.
   assign imem.imem_req_o  = w_req & rst_ni;
   assign imem.imem_addr_o = r_pc;
   assign pc_plus_4_f_o    = w_pc_plus4;
   assign instr_f_o        = rst_ni ? w_instr : 32'h0;
   assign instr_valid_f_o  = w_valid & rst_ni;
   assign imem_stall_o     = w_stall & rst_ni;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: cycle-level stimulus with an instruction scoreboard.
`default_nettype none

module tb_fetch_stage;

   logic        clk_i;
   logic        rst_ni;
   logic        stall_f_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic [31:0] pc_plus_4_f_o;
   logic [31:0] instr_f_o;
   logic        instr_valid_f_o;
   logic        imem_stall_o;

   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] sb_q[$];

   fetch_stage_if u_if ();

   fetch_stage #(.RESET_PC(32'h0000_0000)) u_dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .stall_f_i      (stall_f_i),
      .redirect_i     (redirect_i),
      .redirect_pc_i  (redirect_pc_i),
      .imem           (u_if),
      .pc_plus_4_f_o  (pc_plus_4_f_o),
      .instr_f_o      (instr_f_o),
      .instr_valid_f_o(instr_valid_f_o),
      .imem_stall_o   (imem_stall_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs just after the rising edge, check, then advance.
   // The cache model returns the request address as data when ready, garbage otherwise.
   task automatic cyc(input logic rdy, input logic st, input logic rd, input logic [31:0] rpc,
                      input logic [31:0] e_addr, input logic e_req, input logic e_valid,
                      input logic e_stall);
      logic [63:0] w_ent;
      stall_f_i         = st;
      redirect_i        = rd;
      redirect_pc_i     = rpc;
      u_if.imem_ready_i = rdy;
      u_if.imem_rdata_i = rdy ? u_if.imem_addr_o : 32'hDEAD_BEEF;
      if (e_valid) sb_q.push_back({e_addr, e_addr + 32'd4});
      #1;
      chk("addr",  u_if.imem_addr_o, e_addr);
      chk("pc4",   pc_plus_4_f_o, e_addr + 32'd4);
      chk("req",   {31'b0, u_if.imem_req_o}, {31'b0, e_req});
      chk("stall", {31'b0, imem_stall_o}, {31'b0, e_stall});
      chk("valid", {31'b0, instr_valid_f_o}, {31'b0, e_valid});
      if (instr_valid_f_o) begin
         if (sb_q.size() == 0) begin
            chk("sb_unexpected", 32'd1, 32'd0);
         end else begin
            w_ent = sb_q.pop_front();
            chk("sb_instr", instr_f_o, w_ent[63:32]);
            chk("sb_pc4",   pc_plus_4_f_o, w_ent[31:0]);
         end
      end else begin
         chk("nop", instr_f_o, 32'h0);
      end
      chk("sb_left", sb_q.size(), 32'd0);
      sb_q.delete();
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_ni            = 1'b0;
      stall_f_i         = 1'b0;
      redirect_i        = 1'b0;
      redirect_pc_i     = 32'h0;
      u_if.imem_ready_i = 1'b0;
      u_if.imem_rdata_i = 32'h0;
      #12;
      chk("rst_req",   {31'b0, u_if.imem_req_o}, 32'd0);
      chk("rst_addr",  u_if.imem_addr_o, 32'h0);
      chk("rst_pc4",   pc_plus_4_f_o, 32'h4);
      chk("rst_instr", instr_f_o, 32'h0);
      chk("rst_valid", {31'b0, instr_valid_f_o}, 32'd0);
      chk("rst_stall", {31'b0, imem_stall_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      // zero-wait streaming
      cyc(1, 0, 0, 0, 32'h00, 1, 1, 0);
      cyc(1, 0, 0, 0, 32'h04, 1, 1, 0);
      cyc(1, 0, 0, 0, 32'h08, 1, 1, 0);
      cyc(1, 0, 0, 0, 32'h0C, 1, 1, 0);
      // stall for 4 cycles at 0x10, then release
      cyc(1, 1, 0, 0, 32'h10, 1, 1, 0);
      cyc(0, 1, 0, 0, 32'h10, 0, 1, 0);
      cyc(0, 1, 0, 0, 32'h10, 0, 1, 0);
      cyc(0, 1, 0, 0, 32'h10, 0, 1, 0);
      cyc(0, 0, 0, 0, 32'h10, 0, 1, 0);
      cyc(1, 0, 0, 0, 32'h14, 1, 1, 0);
      cyc(1, 0, 0, 0, 32'h18, 1, 1, 0);
      cyc(1, 0, 0, 0, 32'h1C, 1, 1, 0);
      // redirect to 0x1003 during a miss at 0x20
      cyc(0, 0, 1, 32'h1003, 32'h20, 1, 0, 1);
      cyc(0, 0, 0, 0,        32'h20, 1, 0, 1);
      cyc(1, 0, 0, 0,        32'h20, 1, 0, 1);
      cyc(1, 0, 0, 0,        32'h1000, 1, 1, 0);
      // redirect coincident with ready
      cyc(1, 0, 1, 32'h30, 32'h1004, 1, 1, 0);
      cyc(1, 0, 1, 32'h80, 32'h30, 1, 1, 0);
      cyc(1, 0, 1, 32'h40, 32'h80, 1, 1, 0);
      // 3-wait access at 0x40
      cyc(0, 0, 0, 0, 32'h40, 1, 0, 1);
      cyc(0, 0, 0, 0, 32'h40, 1, 0, 1);
      cyc(0, 0, 0, 0, 32'h40, 1, 0, 1);
      cyc(1, 0, 0, 0, 32'h40, 1, 1, 0);
      cyc(0, 0, 0, 0, 32'h44, 1, 0, 1);
      cyc(1, 0, 0, 0, 32'h44, 1, 1, 0);
      // repeated redirects while discarding: last one wins
      cyc(0, 0, 1, 32'h200, 32'h48, 1, 0, 1);
      cyc(0, 0, 1, 32'h300, 32'h48, 1, 0, 1);
      cyc(1, 0, 1, 32'h400, 32'h48, 1, 0, 1);
      cyc(1, 0, 0, 0,       32'h400, 1, 1, 0);
      // redirect out of HOLD beats stall; then PC wrap
      cyc(1, 1, 0, 0,            32'h404, 1, 1, 0);
      cyc(0, 1, 1, 32'hFFFF_FFFE, 32'h404, 0, 1, 0);
      cyc(1, 0, 0, 0,            32'hFFFF_FFFC, 1, 1, 0);
      cyc(1, 0, 0, 0,            32'h0, 1, 1, 0);
      // asynchronous reset in the middle of a miss at 0x4
      stall_f_i         = 1'b0;
      redirect_i        = 1'b0;
      u_if.imem_ready_i = 1'b0;
      #1;
      chk("miss_req",   {31'b0, u_if.imem_req_o}, 32'd1);
      chk("miss_addr",  u_if.imem_addr_o, 32'h4);
      #1;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_req",   {31'b0, u_if.imem_req_o}, 32'd0);
      chk("mid_rst_addr",  u_if.imem_addr_o, 32'h0);
      chk("mid_rst_stall", {31'b0, imem_stall_o}, 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;
      cyc(1, 0, 0, 0, 32'h0, 1, 1, 0);
      cyc(1, 0, 0, 0, 32'h4, 1, 1, 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
